// File: rtl/sel_pipe_mux.sv
// ----------------------------------------------------------------------------
// sel_pipe_mux
//   N-input, WIDTH-bit selector with a single registered output stage and a
//   valid/ready handshake on both sides.
//   MODE 0: the channel named by sel is routed (operand/result select).
//   MODE 1: round-robin arbitration among valid channels; sel is ignored.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous discard of the output stage; blocks acceptance
//   in_data    NUM_IN*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit set)
//   sel        channel select (MODE 0 only)
//   out_data   registered selected data
//   out_valid  out_data holds an untaken word
//   out_ready  downstream accepts out_data this cycle
//   out_chan   source channel of out_data
//   sel_err    one-cycle pulse when MODE 0 sees valid input with sel >= NUM_IN
// ----------------------------------------------------------------------------
module sel_pipe_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int MODE   = 0,
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_chan,
    output logic                    sel_err
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_IN - 1);
    // A power-of-two channel count leaves no out-of-range sel encodings.
    localparam bit SEL_FULL = (NUM_IN == (1 << SEL_W));
    localparam bit SEL_CHK  = (MODE == 0) && (NUM_IN > 1);

    logic                 load_s;
    logic                 grant_vld_s;
    logic [SEL_W-1:0]     grant_idx_s;
    logic [NUM_IN-1:0]    grant_oh_s;
    logic                 xfer_s;
    logic                 sel_err_s;
    logic [SEL_W-1:0]     rr_next_s;
    logic [WIDTH-1:0]     sel_data_s;

    logic [WIDTH-1:0]     out_data_r;
    logic                 out_valid_r;
    logic [SEL_W-1:0]     out_chan_r;
    logic                 sel_err_r;
    logic [SEL_W-1:0]     rr_ptr_r;

    // sel and rr_ptr are only consumed in some parameterisations.
    logic unused_s;
    assign unused_s = ^{sel, rr_ptr_r};

    generate
        if (NUM_IN == 1) begin : g_single
            // A single channel is always the grant.
            always_comb begin
                grant_vld_s = 1'b1;
                grant_idx_s = '0;
            end
        end else if (MODE == 0) begin : g_sel
            if (SEL_FULL) begin : g_full
                // Every sel encoding names a real channel.
                always_comb begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = sel;
                end
            end else begin : g_part
                // Out-of-range sel grants nothing.
                always_comb begin
                    grant_vld_s = (sel < SEL_W'(NUM_IN));
                    grant_idx_s = sel;
                end
            end
        end else begin : g_rr
            logic [SEL_W-1:0] scan_idx_s;
            logic             hit_s;
            // Scan channels starting at rr_ptr, wrapping, and keep the first valid one.
            always_comb begin
                grant_vld_s = 1'b0;
                grant_idx_s = '0;
                scan_idx_s  = rr_ptr_r;
                hit_s       = 1'b0;
                for (int k = 0; k < NUM_IN; k++) begin
                    hit_s       = ~grant_vld_s & in_valid[scan_idx_s];
                    grant_idx_s = hit_s ? scan_idx_s : grant_idx_s;
                    grant_vld_s = grant_vld_s | hit_s;
                    scan_idx_s  = (scan_idx_s == LAST_CH) ? '0 : scan_idx_s + 1'b1;
                end
            end
        end
    endgenerate

    // Expand the granted index to a one-hot channel mask.
    always_comb begin
        grant_oh_s = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            grant_oh_s[i] = grant_vld_s & (grant_idx_s == SEL_W'(i));
        end
    end

    // Handshake, transfer detect, error detect and next round-robin pointer.
    always_comb begin
        load_s     = (~out_valid_r | out_ready) & ~flush;
        // in_ready is held low while reset is asserted.
        in_ready   = (load_s & ~rst) ? grant_oh_s : '0;
        xfer_s     = |(in_valid & in_ready);
        sel_err_s  = SEL_CHK & load_s & (|in_valid) & ~grant_vld_s;
        rr_next_s  = (grant_idx_s == LAST_CH) ? '0 : grant_idx_s + 1'b1;
        sel_data_s = in_data[int'(grant_idx_s) * WIDTH +: WIDTH];
    end

    // Output stage: flush, then new transfer, then consumption, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_chan_r  <= '0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (xfer_s) begin
            out_data_r  <= sel_data_s;
            out_chan_r  <= grant_idx_s;
            out_valid_r <= 1'b1;
        end else if (out_ready & out_valid_r) begin
            out_valid_r <= 1'b0;
        end
    end

    // Round-robin pointer moves past the channel that just transferred.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if ((MODE == 1) && xfer_s) begin
            rr_ptr_r <= rr_next_s;
        end
    end

    // Select-error pulse lags the offending cycle by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err_r <= 1'b0;
        end else begin
            sel_err_r <= sel_err_s;
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_chan  = out_chan_r;
    assign sel_err   = sel_err_r;

endmodule
